alu_seq_nbit: RTL and testbench

Parametrised, handshaked successor to the team's 32-bit combinational ALU: WIDTH-bit operands, the same AND/OR/ADD/SUB/SLT opcodes plus XOR, NOR and a multi-cycle shift-add MUL, with registered results and status flags. It sits between an operand-issue stage and a writeback consumer, using valid/ready on both sides so either side can stall.

---
 rtl/alu_seq_pkg.sv | 21 ++
 rtl/alu_nbit_core.sv | 54 +++++
 rtl/alu_seq_nbit.sv | 124 ++++++++++++
 tb/tb_alu_seq_nbit.sv | 312 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_seq_pkg.sv
// Shared opcode encodings and FSM state type for the sequential ALU.
package alu_seq_pkg;

    // The five original opcodes keep their encodings; XOR, NOR and MUL fill the gaps
    localparam logic [2:0] OP_AND = 3'b000;
    localparam logic [2:0] OP_OR  = 3'b001;
    localparam logic [2:0] OP_ADD = 3'b010;
    localparam logic [2:0] OP_XOR = 3'b011;
    localparam logic [2:0] OP_NOR = 3'b100;
    localparam logic [2:0] OP_MUL = 3'b101;
    localparam logic [2:0] OP_SUB = 3'b110;
    localparam logic [2:0] OP_SLT = 3'b111;

    // HOLD marks a result sitting on the output while the consumer stalls
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        HOLD = 2'd2
    } state_t;

endpackage

// File: rtl/alu_nbit_core.sv
// Combinational WIDTH-bit logic/add/sub/compare unit with carry and signed
// overflow flags. MUL is not handled here and yields zeros.
module alu_nbit_core
    import alu_seq_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] result,
    output logic             cout,
    output logic             overflow
);

    logic [WIDTH:0] sum_add;
    logic [WIDTH:0] sum_sub;
    logic           add_ovf;
    logic           sub_ovf;

    // One extra bit on each adder captures the unsigned carry-out
    assign sum_add = {1'b0, a} + {1'b0, b};
    assign sum_sub = {1'b0, a} + {1'b0, ~b} + {{WIDTH{1'b0}}, 1'b1};

    // Signed overflow: operand signs versus the sign of the WIDTH-bit result
    assign add_ovf = (a[WIDTH-1] == b[WIDTH-1]) && (sum_add[WIDTH-1] != a[WIDTH-1]);
    assign sub_ovf = (a[WIDTH-1] != b[WIDTH-1]) && (sum_sub[WIDTH-1] != a[WIDTH-1]);

    // Select the result and flags for the requested opcode
    always_comb begin
        result   = '0;
        cout     = 1'b0;
        overflow = 1'b0;
        case (op)
            OP_AND: result = a & b;
            OP_OR:  result = a | b;
            OP_XOR: result = a ^ b;
            OP_NOR: result = ~(a | b);
            OP_ADD: begin
                result   = sum_add[WIDTH-1:0];
                cout     = sum_add[WIDTH];
                overflow = add_ovf;
            end
            OP_SUB: begin
                result   = sum_sub[WIDTH-1:0];
                cout     = sum_sub[WIDTH];
                overflow = sub_ovf;
            end
            OP_SLT: result = {{(WIDTH-1){1'b0}}, sum_sub[WIDTH-1] ^ sub_ovf};
            default: result = '0;
        endcase
    end

endmodule

// File: rtl/alu_seq_nbit.sv
// Handshaked WIDTH-bit ALU: single-cycle logic/arith ops through alu_nbit_core,
// a WIDTH-cycle shift-add multiplier, and registered result/flags with
// valid/ready on both the issue and writeback sides.
module alu_seq_nbit
    import alu_seq_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             cout,
    output logic             overflow,
    output logic             zero
);

    localparam int CW = $clog2(WIDTH);

    state_t             state;
    state_t             state_next;
    logic               accept;
    logic               mul_last;
    logic [WIDTH-1:0]   a_reg;
    logic [WIDTH-1:0]   b_reg;
    logic [2*WIDTH-1:0] acc;
    logic [2*WIDTH-1:0] acc_next;
    logic [CW-1:0]      counter;
    logic [WIDTH-1:0]   core_result;
    logic               core_cout;
    logic               core_overflow;

    alu_nbit_core #(.WIDTH(WIDTH)) u_core (
        .op       (op),
        .a        (a),
        .b        (b),
        .result   (core_result),
        .cout     (core_cout),
        .overflow (core_overflow)
    );

    assign accept = in_valid & in_ready;

    // State register; an asynchronous reset aborts any multiply in flight
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    // Next state: MUL runs WIDTH steps, HOLD tracks a stalled result
    always_comb begin
        state_next = state;
        case (state)
            IDLE, HOLD: begin
                if (accept && op == OP_MUL)        state_next = MUL;
                else if (accept)                   state_next = IDLE;
                else if (out_valid && !out_ready)  state_next = HOLD;
                else                               state_next = IDLE;
            end
            MUL: begin
                if (mul_last) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Handshake and multiplier step; HOLD accepts as soon as the consumer frees the output
    always_comb begin
        in_ready = (state != MUL) && (!out_valid || out_ready);
        mul_last = (state == MUL) && (counter == CW'(WIDTH - 1));
        acc_next = acc;
        if (b_reg[counter]) acc_next = acc + ({{WIDTH{1'b0}}, a_reg} << counter);
    end

    // Multiplier operand latch, accumulator and bit counter
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_reg   <= '0;
            b_reg   <= '0;
            acc     <= '0;
            counter <= '0;
        end else if (accept && op == OP_MUL) begin
            a_reg   <= a;
            b_reg   <= b;
            acc     <= '0;
            counter <= '0;
        end else if (state == MUL) begin
            acc     <= acc_next;
            counter <= mul_last ? '0 : counter + 1'b1;
        end
    end

    // Output register: load on a new result, drop valid once consumed
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            result    <= '0;
            cout      <= 1'b0;
            overflow  <= 1'b0;
            zero      <= 1'b0;
        end else if (accept && op != OP_MUL) begin
            out_valid <= 1'b1;
            result    <= core_result;
            cout      <= core_cout;
            overflow  <= core_overflow;
            zero      <= (core_result == '0);
        end else if (mul_last) begin
            out_valid <= 1'b1;
            result    <= acc_next[WIDTH-1:0];
            cout      <= |acc_next[2*WIDTH-1:WIDTH];
            overflow  <= 1'b0;
            zero      <= (acc_next[WIDTH-1:0] == '0);
        end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_alu_seq_nbit.sv
// Self-checking bench for alu_seq_nbit at WIDTH=32: directed vector table,
// multi-cycle multiply / backpressure / reset sequences, and a randomized
// run scored against an arithmetic reference model.
module tb_alu_seq_nbit;
    import alu_seq_pkg::*;

    localparam longint SMAX = 2147483647;
    localparam longint SMIN = -SMAX - 1;

    typedef struct {
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
        logic        c;
        logic        o;
        logic        z;
    } vec_t;

    typedef struct {
        logic [31:0] res;
        logic        c;
        logic        o;
        logic        z;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [2:0]  op = 3'b000;
    logic [31:0] a = '0;
    logic [31:0] b = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] result;
    logic        cout;
    logic        overflow;
    logic        zero;

    int vectors = 0;
    int miscompares = 0;
    vec_t vecs[12];
    exp_t expq[$];

    alu_seq_nbit #(.WIDTH(32)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .cout      (cout),
        .overflow  (overflow),
        .zero      (zero)
    );

    always #5 clk = ~clk;

    // Reference model computed with wide integer arithmetic
    function automatic exp_t model(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
        exp_t e;
        longint sx;
        longint sy;
        longint s;
        logic [63:0] p;
        sx = $signed(x);
        sy = $signed(y);
        e.res = '0;
        e.c = 1'b0;
        e.o = 1'b0;
        case (o)
            OP_AND: e.res = x & y;
            OP_OR:  e.res = x | y;
            OP_XOR: e.res = x ^ y;
            OP_NOR: e.res = ~(x | y);
            OP_ADD: begin
                p = {32'b0, x} + {32'b0, y};
                e.res = p[31:0];
                e.c = p[32];
                s = sx + sy;
                e.o = (s > SMAX) || (s < SMIN);
            end
            OP_SUB: begin
                e.res = x - y;
                e.c = (x >= y);
                s = sx - sy;
                e.o = (s > SMAX) || (s < SMIN);
            end
            OP_SLT: e.res = (sx < sy) ? 32'd1 : 32'd0;
            default: begin
                p = {32'b0, x} * {32'b0, y};
                e.res = p[31:0];
                e.c = (p[63:32] != 0);
            end
        endcase
        e.z = (e.res == 0);
        return e;
    endfunction

    task automatic checkOutput(input string name, input logic ev, input logic [31:0] er,
                               input logic ec, input logic eo, input logic ez);
        vectors++;
        if (out_valid !== ev || result !== er || cout !== ec || overflow !== eo || zero !== ez) begin
            miscompares++;
            $display("[TB] FAIL %s: got valid=%0b result=%h cout=%0b ovf=%0b zero=%0b, expected valid=%0b result=%h cout=%0b ovf=%0b zero=%0b",
                     name, out_valid, result, cout, overflow, zero, ev, er, ec, eo, ez);
        end
    endtask

    task automatic checkValue(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Present a request at a negedge, wait (bounded) until it is accepted
    task automatic applyStimulus(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
        int n;
        op = o;
        a = x;
        b = y;
        in_valid = 1'b1;
        #1;
        n = 0;
        while (!in_ready && n < 200) begin
            @(negedge clk);
            #1;
            n++;
        end
        if (!in_ready) begin
            vectors++;
            miscompares++;
            $display("[TB] FAIL accept_timeout: in_ready stayed 0, expected 1");
        end
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    // Multiply sequence: latency, in_ready low throughout, then result check
    task automatic runMul(input string name, input logic [31:0] x, input logic [31:0] y,
                          input logic [31:0] er, input logic ec, input logic ez);
        int lat;
        int bad;
        applyStimulus(OP_MUL, x, y);
        lat = 0;
        bad = 0;
        while (!out_valid && lat < 100) begin
            if (in_ready) bad++;
            @(negedge clk);
            lat++;
        end
        checkValue({name, "_latency"}, lat, 32);
        checkValue({name, "_in_ready_busy"}, bad, 0);
        checkOutput(name, 1'b1, er, ec, 1'b0, ez);
        @(negedge clk);
    endtask

    initial begin
        int stray;
        int guard;
        bit hold;
        exp_t e;

        vecs[0]  = '{OP_AND, 32'h55555555, 32'hAAAAAAAA, 32'h00000000, 1'b0, 1'b0, 1'b1};
        vecs[1]  = '{OP_OR,  32'h55555555, 32'hAAAAAAAA, 32'hFFFFFFFF, 1'b0, 1'b0, 1'b0};
        vecs[2]  = '{OP_ADD, 32'h55555555, 32'hAAAAAAAA, 32'hFFFFFFFF, 1'b0, 1'b0, 1'b0};
        vecs[3]  = '{OP_SUB, 32'h55555555, 32'hAAAAAAAA, 32'hAAAAAAAB, 1'b0, 1'b1, 1'b0};
        vecs[4]  = '{OP_SLT, 32'h55555555, 32'hAAAAAAAA, 32'h00000000, 1'b0, 1'b0, 1'b1};
        vecs[5]  = '{OP_SLT, 32'hFFFFFFFF, 32'h00000001, 32'h00000001, 1'b0, 1'b0, 1'b0};
        vecs[6]  = '{OP_XOR, 32'h55555555, 32'hAAAAAAAA, 32'hFFFFFFFF, 1'b0, 1'b0, 1'b0};
        vecs[7]  = '{OP_NOR, 32'h55555555, 32'hAAAAAAAA, 32'h00000000, 1'b0, 1'b0, 1'b1};
        vecs[8]  = '{OP_ADD, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1'b1, 1'b0, 1'b1};
        vecs[9]  = '{OP_ADD, 32'h7FFFFFFF, 32'h00000001, 32'h80000000, 1'b0, 1'b1, 1'b0};
        vecs[10] = '{OP_SUB, 32'h80000000, 32'h00000001, 32'h7FFFFFFF, 1'b1, 1'b1, 1'b0};
        vecs[11] = '{OP_SLT, 32'h80000000, 32'h7FFFFFFF, 32'h00000001, 1'b0, 1'b0, 1'b0};

        // Reset state
        @(negedge clk);
        checkOutput("reset", 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
        rst = 1'b0;
        #1;
        checkValue("in_ready_after_reset", in_ready, 1);

        // Back-to-back table, one op per cycle with out_ready high
        @(negedge clk);
        for (int i = 0; i < 12; i++) begin
            op = vecs[i].op;
            a = vecs[i].a;
            b = vecs[i].b;
            in_valid = 1'b1;
            #1;
            checkValue($sformatf("in_ready_vec%0d", i), in_ready, 1);
            if (i > 0)
                checkOutput($sformatf("vec%0d", i - 1), 1'b1, vecs[i-1].res, vecs[i-1].c, vecs[i-1].o, vecs[i-1].z);
            @(negedge clk);
        end
        in_valid = 1'b0;
        checkOutput("vec11", 1'b1, vecs[11].res, vecs[11].c, vecs[11].o, vecs[11].z);
        @(negedge clk);
        checkValue("valid_clears", out_valid, 0);

        // Multiplies
        runMul("mul_7x6", 32'd7, 32'd6, 32'd42, 1'b0, 1'b0);
        runMul("mul_high", 32'h00010000, 32'h00010000, 32'd0, 1'b1, 1'b1);

        // Backpressure: held ADD result, a second request waits, then both sides move together
        out_ready = 1'b0;
        applyStimulus(OP_ADD, 32'd3, 32'd4);
        op = OP_SUB;
        a = 32'd9;
        b = 32'd4;
        in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            #1;
            checkOutput($sformatf("stall%0d", i), 1'b1, 32'd7, 1'b0, 1'b0, 1'b0);
            checkValue($sformatf("stall%0d_in_ready", i), in_ready, 0);
            @(negedge clk);
        end
        out_ready = 1'b1;
        #1;
        checkValue("release_in_ready", in_ready, 1);
        @(negedge clk);
        in_valid = 1'b0;
        checkOutput("after_release", 1'b1, 32'd5, 1'b1, 1'b0, 1'b0);
        @(negedge clk);
        checkValue("release_valid_clears", out_valid, 0);

        // Reset ten cycles into a multiply
        applyStimulus(OP_MUL, 32'd7, 32'd6);
        repeat (10) @(negedge clk);
        rst = 1'b1;
        #1;
        checkOutput("mid_mul_reset", 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        stray = 0;
        repeat (40) begin
            @(negedge clk);
            if (out_valid) stray++;
        end
        checkValue("no_valid_after_abort", stray, 0);
        applyStimulus(OP_ADD, 32'd1, 32'd1);
        checkOutput("add_after_reset", 1'b1, 32'd2, 1'b0, 1'b0, 1'b0);
        @(negedge clk);

        // Randomized traffic with random consumer stalls against the model
        hold = 1'b0;
        for (int it = 0; it < 400; it++) begin
            out_ready = ($urandom_range(0, 3) != 0);
            if (!hold) begin
                in_valid = ($urandom_range(0, 3) != 0);
                op = 3'($urandom_range(0, 7));
                a = $urandom;
                b = $urandom;
                if ($urandom_range(0, 3) == 0) begin
                    a = a & 32'h0000000F;
                    b = b & 32'h0000000F;
                end
            end
            #1;
            if (out_valid && out_ready) begin
                if (expq.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("[TB] FAIL random_unexpected: got out_valid=1, expected no pending result");
                end else begin
                    e = expq.pop_front();
                    checkOutput("random", 1'b1, e.res, e.c, e.o, e.z);
                end
            end
            if (in_valid && in_ready) begin
                expq.push_back(model(op, a, b));
                hold = 1'b0;
            end else begin
                hold = in_valid;
            end
            @(negedge clk);
        end

        // Drain outstanding results
        in_valid = 1'b0;
        out_ready = 1'b1;
        guard = 0;
        while ((expq.size() != 0 || out_valid) && guard < 100) begin
            #1;
            if (out_valid) begin
                if (expq.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("[TB] FAIL drain_unexpected: got out_valid=1, expected no pending result");
                end else begin
                    e = expq.pop_front();
                    checkOutput("drain", 1'b1, e.res, e.c, e.o, e.z);
                end
            end
            @(negedge clk);
            guard++;
        end
        checkValue("drain_pending", expq.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
